// File: rtl/aes_channel_arbiter.sv
// aes_channel_arbiter: round-robin scheduler sharing one aes_encryptor among NUM_CH sources.
// Arbitrates in IDLE, hands the winner's key/sync over in LOAD_KEY, then passes its message
// through in STREAM until eop. Define AES_ARB_WATCHDOG_EN to add a STREAM stall watchdog (wd_error_o).
module aes_channel_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int WATCHDOG_CYCLES = 1024,
    localparam int W = 8 * DATA_WIDTH_IN_BYTES,
    localparam int EW = $clog2(DATA_WIDTH_IN_BYTES),
    localparam int GW = $clog2(NUM_CH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_CH*W-1:0]  req_key_i,
    input  logic [NUM_CH*W-1:0]  req_sync_i,
    input  logic [NUM_CH-1:0]    req_key_valid_i,
    output logic [NUM_CH-1:0]    req_key_rdy_o,
    input  logic [NUM_CH*W-1:0]  req_data_i,
    input  logic [NUM_CH-1:0]    req_valid_i,
    input  logic [NUM_CH-1:0]    req_sop_i,
    input  logic [NUM_CH-1:0]    req_eop_i,
    input  logic [NUM_CH*EW-1:0] req_empty_i,
    output logic [NUM_CH-1:0]    req_rdy_o,
    output logic [W-1:0]         enc_key_o,
    output logic [W-1:0]         enc_sync_o,
    output logic                 enc_key_valid_o,
    input  logic                 enc_key_rdy_i,
    output logic [W-1:0]         enc_data_o,
    output logic                 enc_valid_o,
    output logic                 enc_sop_o,
    output logic                 enc_eop_o,
    output logic [EW-1:0]        enc_empty_o,
    input  logic                 enc_rdy_i,
    output logic [GW-1:0]        grant_id_o,
    output logic                 busy_o
`ifdef AES_ARB_WATCHDOG_EN
    ,
    output logic                 wd_error_o
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD_KEY, STREAM} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
    logic          found, key_hs, xfer, done, wd_fire;

    assign key_hs = state_q == LOAD_KEY && req_key_valid_i[grant_q] && enc_key_rdy_i;
    assign xfer   = state_q == STREAM && req_valid_i[grant_q] && enc_rdy_i;
    assign done   = xfer && req_eop_i[grant_q];

    // first requesting channel scanning upward from the one after last_q, wrapping
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = GW'((int'(last_q) + i) % NUM_CH);
            if (!found && req_key_valid_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

`ifdef AES_ARB_WATCHDOG_EN
    localparam int CW = $clog2(WATCHDOG_CYCLES) + 1;
    logic [CW-1:0] wd_q, wd_d;

    assign wd_fire    = state_q == STREAM && !xfer && wd_q == CW'(WATCHDOG_CYCLES - 1);
    assign wd_error_o = wd_fire;

    // count consecutive STREAM cycles without a beat; zero everywhere else
    always_comb wd_d = (state_q == STREAM && !xfer) ? wd_q + 1'b1 : '0;

    // stall counter register
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) wd_q <= '0;
        else         wd_q <= wd_d;
`else
    assign wd_fire = 1'b0;
`endif

    // state, grant and round-robin pointer registers
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end

    // next state: re-arbitrate only after eop (or a watchdog abort)
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick;
                state_d = LOAD_KEY;
            end
            LOAD_KEY: if (key_hs) state_d = STREAM;
            STREAM: if (done || wd_fire) begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs: granted channel's key in LOAD_KEY, its beats in STREAM, zeros otherwise
    always_comb begin
        enc_key_o       = '0;
        enc_sync_o      = '0;
        enc_key_valid_o = 1'b0;
        req_key_rdy_o   = '0;
        enc_data_o      = '0;
        enc_valid_o     = 1'b0;
        enc_sop_o       = 1'b0;
        enc_eop_o       = 1'b0;
        enc_empty_o     = '0;
        req_rdy_o       = '0;
        if (state_q == LOAD_KEY) begin
            enc_key_o              = req_key_i[int'(grant_q)*W +: W];
            enc_sync_o             = req_sync_i[int'(grant_q)*W +: W];
            enc_key_valid_o        = req_key_valid_i[grant_q];
            req_key_rdy_o[grant_q] = key_hs;
        end
        if (state_q == STREAM) begin
            enc_data_o         = req_data_i[int'(grant_q)*W +: W];
            enc_empty_o        = req_empty_i[int'(grant_q)*EW +: EW];
            enc_valid_o        = req_valid_i[grant_q];
            enc_sop_o          = req_sop_i[grant_q];
            enc_eop_o          = req_eop_i[grant_q];
            req_rdy_o[grant_q] = enc_rdy_i;
        end
    end

    assign grant_id_o = grant_q;
    assign busy_o     = state_q != IDLE;

endmodule

// File: tb/tb_aes_channel_arbiter.sv
// tb_aes_channel_arbiter: randomized self-checking bench for aes_channel_arbiter.
`timescale 1ns/1ps
module tb_aes_channel_arbiter;

    localparam int N = 4, W = 128, EW = 4, GW = 2;

    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic [N*W-1:0]  req_key_i, req_sync_i, req_data_i;
    logic [N-1:0]    req_key_valid_i, req_key_rdy_o, req_valid_i, req_sop_i, req_eop_i, req_rdy_o;
    logic [N*EW-1:0] req_empty_i;
    logic [W-1:0]    enc_key_o, enc_sync_o, enc_data_o;
    logic            enc_key_valid_o, enc_key_rdy_i, enc_valid_o, enc_sop_o, enc_eop_o, enc_rdy_i, busy_o;
    logic [EW-1:0]   enc_empty_o;
    logic [GW-1:0]   grant_id_o;
`ifdef AES_ARB_WATCHDOG_EN
    logic            wd_error_o;
`endif

    int checks = 0, passed = 0;
    int exp_last = N - 1;

    aes_channel_arbiter #(
        .NUM_CH(N), .DATA_WIDTH_IN_BYTES(16)
`ifdef AES_ARB_WATCHDOG_EN
        , .WATCHDOG_CYCLES(8)
`endif
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_key_i(req_key_i), .req_sync_i(req_sync_i),
        .req_key_valid_i(req_key_valid_i), .req_key_rdy_o(req_key_rdy_o),
        .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_sop_i(req_sop_i),
        .req_eop_i(req_eop_i), .req_empty_i(req_empty_i), .req_rdy_o(req_rdy_o),
        .enc_key_o(enc_key_o), .enc_sync_o(enc_sync_o), .enc_key_valid_o(enc_key_valid_o),
        .enc_key_rdy_i(enc_key_rdy_i), .enc_data_o(enc_data_o), .enc_valid_o(enc_valid_o),
        .enc_sop_o(enc_sop_o), .enc_eop_o(enc_eop_o), .enc_empty_o(enc_empty_o),
        .enc_rdy_i(enc_rdy_i), .grant_id_o(grant_id_o), .busy_o(busy_o)
`ifdef AES_ARB_WATCHDOG_EN
        , .wd_error_o(wd_error_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 3ms");
        $fatal(1);
    end

    function automatic logic [N*W-1:0] rand_wide();
        logic [N*W-1:0] r;
        for (int i = 0; i < N*W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // round-robin rule: first requester after the last granted channel, modulo N
    function automatic int pick(input int last, input logic [N-1:0] reqs);
        for (int i = 1; i <= N; i++) if (reqs[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic quiet_inputs();
        req_key_valid_i = '0;
        req_valid_i = '0;
        req_sop_i = '0;
        req_eop_i = '0;
        enc_key_rdy_i = 1'b0;
        enc_rdy_i = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        exp_last = N - 1;
    endtask

    // one full arbitration + key load + message; DUT must be in IDLE on entry
    task automatic serve(input logic [N-1:0] reqs, input int nbeats, input int key_stall,
                         input bit rnd, input bit fixk, input logic [W-1:0] kval, output int gobs);
        int g, beat, cyc;
        logic v, r;
        logic [W-1:0] k, s, d;
        logic [EW-1:0] e;
        logic [N-1:0] rexp;
        g = pick(exp_last, reqs);
        req_key_i = rand_wide();
        req_sync_i = rand_wide();
        if (fixk) req_key_i[g*W +: W] = kval;
        k = req_key_i[g*W +: W];
        s = req_sync_i[g*W +: W];
        req_key_valid_i = reqs;
        req_valid_i = '0;
        enc_key_rdy_i = 1'b0;
        enc_rdy_i = 1'b0;
        gobs = -1;
        @(negedge clk_i);
        checks++;
        if ({busy_o, enc_key_valid_o, enc_valid_o, req_key_rdy_o, req_rdy_o} !== 11'b0)
            $display("FAIL idle_outputs: got %b, required 0", {busy_o, enc_key_valid_o, enc_valid_o, req_key_rdy_o, req_rdy_o});
        else passed++;
        @(posedge clk_i); #1;
        for (int i = 0; i <= key_stall; i++) begin
            enc_key_rdy_i = (i == key_stall);
            @(negedge clk_i);
            if (i == 0) gobs = int'(grant_id_o);
            checks++;
            if (grant_id_o !== GW'(g)) $display("FAIL grant: got %0d, required %0d", grant_id_o, g);
            else passed++;
            checks++;
            if ({busy_o, enc_key_valid_o, enc_valid_o, req_rdy_o} !== 7'b1100000)
                $display("FAIL load_key_ctl: got %b, required 1100000", {busy_o, enc_key_valid_o, enc_valid_o, req_rdy_o});
            else passed++;
            checks++;
            if ({enc_key_o, enc_sync_o} !== {k, s})
                $display("FAIL key_fwd: got %h/%h, required %h/%h", enc_key_o, enc_sync_o, k, s);
            else passed++;
            rexp = (i == key_stall) ? (4'b1 << g) : 4'b0;
            checks++;
            if (req_key_rdy_o !== rexp) $display("FAIL key_rdy: got %b, required %b", req_key_rdy_o, rexp);
            else passed++;
            @(posedge clk_i); #1;
        end
        req_key_valid_i[g] = 1'b0;
        enc_key_rdy_i = 1'b0;
        beat = 0;
        cyc = 0;
        while (beat < nbeats && cyc < 200) begin
            v = rnd ? ($urandom_range(3) != 0) : 1'b1;
            r = rnd ? ($urandom_range(3) != 0) : (cyc % 4 != 1 && cyc % 4 != 2);
            req_data_i = rand_wide();
            req_empty_i = 16'($urandom);
            req_valid_i = 4'($urandom);
            req_sop_i = 4'($urandom);
            req_eop_i = 4'($urandom);
            req_valid_i[g] = v;
            req_sop_i[g] = (beat == 0);
            req_eop_i[g] = (beat == nbeats - 1);
            enc_rdy_i = r;
            d = req_data_i[g*W +: W];
            e = req_empty_i[g*EW +: EW];
            rexp = r ? (4'b1 << g) : 4'b0;
            @(negedge clk_i);
            checks++;
            if ({enc_valid_o, enc_sop_o, enc_eop_o, enc_empty_o, enc_data_o} !== {v, beat == 0, beat == nbeats - 1, e, d})
                $display("FAIL beat%0d: got v%b s%b e%b m%h %h, required v%b s%b e%b m%h %h", beat,
                         enc_valid_o, enc_sop_o, enc_eop_o, enc_empty_o, enc_data_o, v, beat == 0, beat == nbeats - 1, e, d);
            else passed++;
            checks++;
            if ({req_rdy_o, req_key_rdy_o, enc_key_valid_o, busy_o} !== {rexp, 4'b0, 1'b0, 1'b1})
                $display("FAIL stream_ctl: got rdy %b krdy %b kv %b busy %b, required rdy %b krdy 0000 kv 0 busy 1",
                         req_rdy_o, req_key_rdy_o, enc_key_valid_o, busy_o, rexp);
            else passed++;
            @(posedge clk_i); #1;
            if (v && r) beat++;
            cyc++;
        end
        checks++;
        if (beat < nbeats) $display("FAIL stream_timeout: sent %0d beats, required %0d", beat, nbeats);
        else passed++;
        exp_last = g;
        req_valid_i = '0;
        req_sop_i = '0;
        req_eop_i = '0;
        enc_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        req_key_i = rand_wide();
        req_sync_i = rand_wide();
        req_data_i = rand_wide();
        req_empty_i = 16'($urandom);
        req_key_valid_i = '1;
        req_valid_i = '1;
        enc_key_rdy_i = 1'b1;
        enc_rdy_i = 1'b1;
        rst_ni = 1'b0;
        #12;
        checks++;
        if ({busy_o, enc_key_valid_o, enc_valid_o, enc_sop_o, enc_eop_o, req_key_rdy_o, req_rdy_o, grant_id_o} !== 15'b0)
            $display("FAIL reset_ctl: got %b, required 0", {busy_o, enc_key_valid_o, enc_valid_o, enc_sop_o, enc_eop_o, req_key_rdy_o, req_rdy_o, grant_id_o});
        else passed++;
        checks++;
        if ({enc_key_o, enc_sync_o, enc_data_o, enc_empty_o} !== '0)
            $display("FAIL reset_data: got %h, required 0", {enc_key_o, enc_sync_o, enc_data_o, enc_empty_o});
        else passed++;
        quiet_inputs();
        @(posedge clk_i); #1 rst_ni = 1'b1;
        exp_last = N - 1;
        @(posedge clk_i); #1;
        checks++;
        if ({busy_o, grant_id_o} !== 3'b0) $display("FAIL reset_idle: got %b, required 000", {busy_o, grant_id_o});
        else passed++;
    endtask

    task automatic test_single();
        int gobs;
        serve(4'b0100, 3, 0, 1'b0, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, gobs);
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) $display("FAIL busy_after_eop: got %b, required 0", busy_o);
        else passed++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_fairness();
        int gobs;
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            serve(4'b1111, 1, 0, 1'b1, 1'b0, '0, gobs);
            checks++;
            if (gobs !== exp_seq[i]) $display("FAIL fair_order[%0d]: got %0d, required %0d", i, gobs, exp_seq[i]);
            else passed++;
        end
    endtask

    task automatic test_rdy_toggle();
        int gobs;
        serve(4'b0010, 3, 0, 1'b0, 1'b0, '0, gobs);
    endtask

    task automatic test_key_stall();
        int gobs;
        serve(4'b1000, 2, 5, 1'b1, 1'b0, '0, gobs);
    endtask

    task automatic test_reset_mid();
        int gobs;
        quiet_inputs();
        req_key_i = rand_wide();
        req_key_valid_i = 4'b0100;
        enc_key_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        req_key_valid_i = '0;
        enc_key_rdy_i = 1'b0;
        req_data_i = rand_wide();
        req_valid_i = 4'b0100;
        req_sop_i = 4'b0100;
        enc_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        req_sop_i = '0;
        req_data_i = rand_wide();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, enc_key_valid_o, enc_valid_o, req_key_rdy_o, req_rdy_o, grant_id_o} !== 13'b0)
            $display("FAIL mid_reset_ctl: got %b, required 0", {busy_o, enc_key_valid_o, enc_valid_o, req_key_rdy_o, req_rdy_o, grant_id_o});
        else passed++;
        checks++;
        if (enc_data_o !== '0) $display("FAIL mid_reset_data: got %h, required 0", enc_data_o);
        else passed++;
        @(posedge clk_i); #1 rst_ni = 1'b1;
        exp_last = N - 1;
        @(negedge clk_i);
        checks++;
        if ({busy_o, enc_valid_o} !== 2'b0) $display("FAIL no_resume: got busy/valid %b, required 00", {busy_o, enc_valid_o});
        else passed++;
        @(posedge clk_i); #1;
        quiet_inputs();
        serve(4'b0101, 2, 0, 1'b1, 1'b0, '0, gobs);
        checks++;
        if (gobs !== 0) $display("FAIL first_after_reset: got %0d, required 0", gobs);
        else passed++;
    endtask

    task automatic test_random();
        int gobs;
        logic [N-1:0] reqs;
        for (int i = 0; i < 25; i++) begin
            reqs = 4'($urandom_range(15, 1));
            serve(reqs, $urandom_range(4, 1), $urandom_range(2), 1'b1, 1'b0, '0, gobs);
        end
    endtask

`ifdef AES_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        req_key_i = rand_wide();
        req_key_valid_i = 4'b0011;
        enc_key_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        req_key_valid_i = 4'b0010;
        enc_key_rdy_i = 1'b0;
        req_valid_i = 4'b0001;
        req_sop_i = 4'b0001;
        enc_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = '0;
        req_sop_i = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            checks++;
            if (wd_error_o !== (k == 8)) $display("FAIL wd_stall%0d: got %b, required %b", k, wd_error_o, k == 8);
            else passed++;
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        checks++;
        if ({busy_o, wd_error_o} !== 2'b0) $display("FAIL wd_idle: got %b, required 00", {busy_o, wd_error_o});
        else passed++;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if ({grant_id_o, enc_key_valid_o} !== {2'd1, 1'b1}) $display("FAIL wd_next_grant: got %0d/%b, required 1/1", grant_id_o, enc_key_valid_o);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_rdy_toggle();
        test_key_stall();
        test_reset_mid();
        test_random();
`ifdef AES_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
